// File: rtl/uart_loader.sv
// UART program/data loader: 8N1 receiver plus framed command parser driving memory write ports.
// Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte after each data section.
module uart_loader #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned BAUD   = 128_000,
    parameter logic [7:0]  CMD_I  = 8'h49,
    parameter logic [7:0]  CMD_D  = 8'h44,
    parameter logic [7:0]  CMD_E  = 8'h45
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic        upg_rx_i,
    output logic        upg_clk_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);
    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] L_CMD  = 3'd0;
    localparam logic [2:0] L_CNT0 = 3'd1;
    localparam logic [2:0] L_CNT1 = 3'd2;
    localparam logic [2:0] L_DATA = 3'd3;
    localparam logic [2:0] L_DONE = 3'd4;
`ifdef UPG_CHECKSUM_EN
    localparam logic [2:0] L_SUM  = 3'd5;
`endif

    assign upg_clk_o = upg_clk_i;

    // ---------------- RX sampler ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err;

    always_comb begin
        rx_st_d      = rx_st_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                cnt_d = '0;
                // A falling edge needs the line seen high first, so a stuck-low
                // line after a framing error cannot retrigger.
                if (rx_prev_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_st_d = RX_STOP;
                end
            end
            default: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d        = '0;
                    rx_st_d      = RX_IDLE;
                    byte_valid_d = rx_s2_q;
                    frame_err    = !rx_s2_q;
                end
            end
        endcase
    end

    // ---------------- Loader FSM ----------------
    logic [2:0]  ld_st_q, ld_st_d;
    logic        base_q, base_d;
    logic [15:0] n_q, n_d;
    logic [13:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] word_q, word_d;
    logic        wen_q, wen_d;
    logic [14:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef UPG_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        sum_bad_q, sum_bad_d;
`endif
    logic [7:0]  rx_byte;

    assign rx_byte = shift_q;

    always_comb begin
        ld_st_d = ld_st_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        word_d  = word_q;
        wen_d   = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        done_d  = done_q;
        err_d   = err_q | frame_err;
`ifdef UPG_CHECKSUM_EN
        sum_d     = sum_q;
        sum_bad_d = sum_bad_q;
`endif
        if (byte_valid_q) begin
            case (ld_st_q)
                L_CMD: begin
                    if (rx_byte == CMD_I || rx_byte == CMD_D) begin
                        base_d  = (rx_byte == CMD_D);
                        ld_st_d = L_CNT0;
`ifdef UPG_CHECKSUM_EN
                        sum_d   = rx_byte;
`endif
                    end else if (rx_byte == CMD_E) begin
`ifdef UPG_CHECKSUM_EN
                        if (!sum_bad_q) begin
                            ld_st_d = L_DONE;
                            done_d  = 1'b1;
                        end
`else
                        ld_st_d = L_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                L_CNT0: begin
                    n_d[7:0] = rx_byte;
                    ld_st_d  = L_CNT1;
`ifdef UPG_CHECKSUM_EN
                    sum_d    = sum_q ^ rx_byte;
`endif
                end
                L_CNT1: begin
                    n_d[15:8] = rx_byte;
                    idx_d     = '0;
                    lane_d    = '0;
                    ld_st_d   = ({rx_byte, n_q[7:0]} == 16'd0) ? L_CMD : L_DATA;
`ifdef UPG_CHECKSUM_EN
                    sum_d     = sum_q ^ rx_byte;
`endif
                end
                L_DATA: begin
`ifdef UPG_CHECKSUM_EN
                    sum_d = sum_q ^ rx_byte;
`endif
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_byte;
                        2'd1: word_d[15:8]  = rx_byte;
                        2'd2: word_d[23:16] = rx_byte;
                        default: begin
                            wen_d = 1'b1;
                            adr_d = {base_q, idx_q};
                            dat_d = {rx_byte, word_q};
                            idx_d = idx_q + 14'd1;
                            n_d   = n_q - 16'd1;
                            if (n_q == 16'd1) begin
`ifdef UPG_CHECKSUM_EN
                                ld_st_d = L_SUM;
`else
                                ld_st_d = L_CMD;
`endif
                            end
                        end
                    endcase
                    lane_d = lane_q + 2'd1;
                end
`ifdef UPG_CHECKSUM_EN
                L_SUM: begin
                    if (rx_byte != sum_q) begin
                        err_d     = 1'b1;
                        sum_bad_d = 1'b1;
                    end
                    ld_st_d = L_CMD;
                end
`endif
                L_DONE: ;
                default: ld_st_d = L_CMD;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_st_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            ld_st_q      <= L_CMD;
            base_q       <= 1'b0;
            n_q          <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            wen_q        <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef UPG_CHECKSUM_EN
            sum_q        <= '0;
            sum_bad_q    <= 1'b0;
`endif
        end else begin
            rx_s1_q      <= upg_rx_i;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_st_q      <= rx_st_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            ld_st_q      <= ld_st_d;
            base_q       <= base_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            wen_q        <= wen_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef UPG_CHECKSUM_EN
            sum_q        <= sum_d;
            sum_bad_q    <= sum_bad_d;
`endif
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table-driven command streams plus glitch, framing, reset and checksum sequences.
`timescale 1ns/1ps
module tb_uart_loader;
    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DIV    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        upg_clk_o, upg_wen_o, upg_done_o, upg_err_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    always #5 clk = ~clk;

    uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .upg_clk_i (clk),
        .upg_rst_i (rst),
        .upg_rx_i  (rx),
        .upg_clk_o (upg_clk_o),
        .upg_wen_o (upg_wen_o),
        .upg_adr_o (upg_adr_o),
        .upg_dat_o (upg_dat_o),
        .upg_done_o(upg_done_o),
        .upg_err_o (upg_err_o)
    );

    typedef struct packed {
        logic [159:0]      bytes;   // first byte in the most significant used position
        logic [4:0]        n;
        logic [1:0]        nw;
        logic [2:0][14:0]  adr;
        logic [2:0][31:0]  dat;
        logic              done;
        logic              err;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [14:0] wr_adr[$];
    logic [31:0] wr_dat[$];

    always @(negedge clk) begin
        if (upg_wen_o) begin
            wr_adr.push_back(upg_adr_o);
            wr_dat.push_back(upg_dat_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
        tick(DIV);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2 * DIV);
        wr_adr.delete();
        wr_dat.delete();
    endtask

    task automatic expect_write(input string tag, input int unsigned k,
                                input logic [14:0] adr, input logic [31:0] dat);
        if (k < wr_adr.size()) begin
            check($sformatf("%s_adr%0d", tag, k), {17'd0, wr_adr[k]}, {17'd0, adr});
            check($sformatf("%s_dat%0d", tag, k), wr_dat[k], dat);
        end
    endtask

    function automatic vec_t mk(input logic [159:0] b, input int unsigned n, input int unsigned nw,
                                input logic [14:0] a0, input logic [31:0] d0,
                                input logic [14:0] a1, input logic [31:0] d1,
                                input logic [14:0] a2, input logic [31:0] d2,
                                input logic done, input logic err);
        vec_t v;
        v.bytes = b;
        v.n     = 5'(n);
        v.nw    = 2'(nw);
        v.adr[0] = a0; v.dat[0] = d0;
        v.adr[1] = a1; v.dat[1] = d1;
        v.adr[2] = a2; v.dat[2] = d2;
        v.done  = done;
        v.err   = err;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = mk({8'h49, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h45}, 8, 1,
                     15'h0000, 32'h12345678, 15'h0, 32'h0, 15'h0, 32'h0, 1'b1, 1'b0);
        vecs[1] = mk({8'h44, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45},
                     12, 2, 15'h4000, 32'hDDCCBBAA, 15'h4001, 32'h44332211, 15'h0, 32'h0, 1'b1, 1'b0);
        vecs[2] = mk({8'h49, 8'h00, 8'h00, 8'h45}, 4, 0,
                     15'h0, 32'h0, 15'h0, 32'h0, 15'h0, 32'h0, 1'b1, 1'b0);
        vecs[3] = mk({8'h7F, 8'h49, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 8, 1,
                     15'h0000, 32'hDEADBEEF, 15'h0, 32'h0, 15'h0, 32'h0, 1'b0, 1'b1);
        vecs[4] = mk({8'h49, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                      8'h44, 8'h01, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'h45}, 19, 3,
                     15'h0000, 32'h00000001, 15'h0001, 32'h00000002, 15'h4000, 32'hCCDDEEFF, 1'b1, 1'b0);
        vecs[5] = mk({8'h45, 8'h49, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 8, 0,
                     15'h0, 32'h0, 15'h0, 32'h0, 15'h0, 32'h0, 1'b1, 1'b0);

        tick(1);
        do_reset();
        check("rst_wen",  {31'd0, upg_wen_o},  32'd0);
        check("rst_done", {31'd0, upg_done_o}, 32'd0);
        check("rst_err",  {31'd0, upg_err_o},  32'd0);

`ifndef UPG_CHECKSUM_EN
        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            do_reset();
            for (int i = 0; i < int'(vecs[v].n); i++)
                send_byte(vecs[v].bytes[8*(int'(vecs[v].n)-1-i) +: 8], 1'b1);
            tick(2 * DIV);
            check({tag, "_nw"}, 32'(wr_adr.size()), {30'd0, vecs[v].nw});
            for (int k = 0; k < int'(vecs[v].nw); k++)
                expect_write(tag, k, vecs[v].adr[k], vecs[v].dat[k]);
            check({tag, "_done"}, {31'd0, upg_done_o}, {31'd0, vecs[v].done});
            check({tag, "_err"},  {31'd0, upg_err_o},  {31'd0, vecs[v].err});
            if (vecs[v].nw != 0) begin
                check({tag, "_hold_adr"}, {17'd0, upg_adr_o}, {17'd0, vecs[v].adr[vecs[v].nw - 1]});
                check({tag, "_hold_dat"}, upg_dat_o, vecs[v].dat[vecs[v].nw - 1]);
            end
        end

        // Short low glitch must be rejected without producing a byte or an error.
        do_reset();
        rx = 1'b0;
        tick(DIV / 4);
        rx = 1'b1;
        tick(3 * DIV);
        send_byte(8'h49, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h01, 1'b1);
        tick(2 * DIV);
        check("glitch_err", {31'd0, upg_err_o}, 32'd0);
        check("glitch_nw", 32'(wr_adr.size()), 32'd1);
        expect_write("glitch", 0, 15'h0000, 32'h01020304);

        // Bad stop bit: byte dropped, err set, following section still parses.
        wr_adr.delete();
        wr_dat.delete();
        send_byte(8'h44, 1'b0);
        tick(DIV);
        check("frame_err", {31'd0, upg_err_o}, 32'd1);
        send_byte(8'h44, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        tick(2 * DIV);
        check("frame_nw", 32'(wr_adr.size()), 32'd1);
        expect_write("frame", 0, 15'h4000, 32'hDEADBEEF);

        // Reset mid-word clears outputs and partial state.
        send_byte(8'h49, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        do_reset();
        check("midrst_adr", {17'd0, upg_adr_o}, 32'd0);
        check("midrst_dat", upg_dat_o, 32'd0);
        check("midrst_err", {31'd0, upg_err_o}, 32'd0);
        check("midrst_done", {31'd0, upg_done_o}, 32'd0);
        send_byte(8'h49, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        tick(2 * DIV);
        check("midrst_nw", 32'(wr_adr.size()), 32'd1);
        expect_write("midrst", 0, 15'h0000, 32'h12345678);
`else
        for (int pass = 0; pass < 2; pass++) begin
            logic [7:0] seq[7];
            logic [7:0] sum;
            string tag;
            tag = (pass == 0) ? "sum_ok" : "sum_bad";
            seq = '{8'h49, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
            sum = 8'h00;
            do_reset();
            for (int i = 0; i < 7; i++) begin
                sum = sum ^ seq[i];
                send_byte(seq[i], 1'b1);
            end
            send_byte((pass == 0) ? sum : 8'h00, 1'b1);
            tick(DIV);
            check({tag, "_err"}, {31'd0, upg_err_o}, (pass == 0) ? 32'd0 : 32'd1);
            check({tag, "_nw"}, 32'(wr_adr.size()), 32'd1);
            expect_write(tag, 0, 15'h0000, 32'h04030201);
            send_byte(8'h45, 1'b1);
            tick(DIV);
            check({tag, "_done"}, {31'd0, upg_done_o}, (pass == 0) ? 32'd1 : 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
